// File: rtl/capture_sequencer.sv
// Capture sequencer for the logic-analyzer channel RAMs: write addressing,
// pre-trigger fill tracking, post-trigger counting and completion pulse.
module capture_sequencer #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            capture_done,
  input  logic            smpl_en,
  input  logic            trig,
  input  logic [LOG2-1:0] trig_pos,
  output logic            we,
  output logic [LOG2-1:0] waddr,
  output logic [LOG2-1:0] ram_addr,
  output logic            armed,
  output logic            triggered,
  output logic            capturing,
  output logic            set_capture_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [LOG2:0]   ENTRIES_W = (LOG2+1)'(ENTRIES);
  localparam logic [LOG2-1:0] LAST_ADDR = LOG2'(ENTRIES - 1);
  localparam logic [LOG2-1:0] ONE       = LOG2'(1'b1);

  state_e          state_r, state_s;
  logic [LOG2-1:0] waddr_r, waddr_s;
  logic [LOG2-1:0] ram_addr_r, ram_addr_s;
  logic [LOG2-1:0] smpl_cnt_r, smpl_cnt_s;
  logic [LOG2-1:0] post_cnt_r, post_cnt_s;
  logic            armed_r, armed_s;
  logic            triggered_r, triggered_s;
  logic            done_r, done_s;
  logic [LOG2-1:0] post_len_s;
  logic [LOG2-1:0] fill_len_s;
  logic            in_capture_s;
  logic            abort_s;
  logic            wr_s;

  // Clamp the trigger position into [1, ENTRIES-1] and derive the pre-fill target.
  always_comb begin
    post_len_s = trig_pos;
    if (trig_pos == '0) begin
      post_len_s = ONE;
    end else if ({1'b0, trig_pos} >= ENTRIES_W) begin
      post_len_s = LAST_ADDR;
    end else begin
      post_len_s = trig_pos;
    end
    fill_len_s = LOG2'(ENTRIES_W - {1'b0, post_len_s});
  end

  // A sample strobe landing in an abort cycle is dropped rather than written.
  assign in_capture_s = (state_r == ST_PRE) || (state_r == ST_POST);
  assign abort_s      = in_capture_s && (!run || capture_done);
  assign wr_s         = in_capture_s && smpl_en && !abort_s;

  // Next-state, address and counter updates.
  always_comb begin
    state_s     = state_r;
    waddr_s     = waddr_r;
    ram_addr_s  = ram_addr_r;
    smpl_cnt_s  = smpl_cnt_r;
    post_cnt_s  = post_cnt_r;
    armed_s     = armed_r;
    triggered_s = triggered_r;
    done_s      = 1'b0;

    if (wr_s) begin
      ram_addr_s = waddr_r;
      if (waddr_r == LAST_ADDR) begin
        waddr_s = '0;
      end else begin
        waddr_s = waddr_r + ONE;
      end
    end else begin
      ram_addr_s = ram_addr_r;
      waddr_s    = waddr_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (run && !capture_done) begin
          state_s     = ST_PRE;
          waddr_s     = '0;
          smpl_cnt_s  = '0;
          post_cnt_s  = '0;
          armed_s     = 1'b0;
          triggered_s = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PRE: begin
        if (abort_s) begin
          state_s     = ST_IDLE;
          armed_s     = 1'b0;
          triggered_s = 1'b0;
        end else begin
          if (smpl_en) begin
            if (smpl_cnt_r < fill_len_s) begin
              smpl_cnt_s = smpl_cnt_r + ONE;
            end else begin
              smpl_cnt_s = smpl_cnt_r;
            end
            if (smpl_cnt_s >= fill_len_s) begin
              armed_s = 1'b1;
            end else begin
              armed_s = armed_r;
            end
          end else begin
            smpl_cnt_s = smpl_cnt_r;
          end
          // Trigger is qualified by the arming state from before this cycle's write.
          if (trig && armed_r) begin
            state_s     = ST_POST;
            triggered_s = 1'b1;
          end else begin
            state_s = ST_PRE;
          end
        end
      end
      ST_POST: begin
        if (abort_s) begin
          state_s     = ST_IDLE;
          armed_s     = 1'b0;
          triggered_s = 1'b0;
        end else if (smpl_en) begin
          post_cnt_s = post_cnt_r + ONE;
          if (post_cnt_s == post_len_s) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end else begin
            state_s = ST_POST;
          end
        end else begin
          state_s = ST_POST;
        end
      end
      ST_DONE: begin
        if (!capture_done && run) begin
          state_s     = ST_PRE;
          waddr_s     = '0;
          smpl_cnt_s  = '0;
          post_cnt_s  = '0;
          armed_s     = 1'b0;
          triggered_s = 1'b0;
        end else if (!capture_done) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      waddr_r     <= '0;
      ram_addr_r  <= '0;
      smpl_cnt_r  <= '0;
      post_cnt_r  <= '0;
      armed_r     <= 1'b0;
      triggered_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      waddr_r     <= waddr_s;
      ram_addr_r  <= ram_addr_s;
      smpl_cnt_r  <= smpl_cnt_s;
      post_cnt_r  <= post_cnt_s;
      armed_r     <= armed_s;
      triggered_r <= triggered_s;
      done_r      <= done_s;
    end
  end

  assign we               = wr_s;
  assign waddr            = waddr_r;
  assign ram_addr         = ram_addr_r;
  assign armed            = armed_r;
  assign triggered        = triggered_r;
  assign capturing        = in_capture_s;
  assign set_capture_done = done_r;

endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer (ENTRIES=8): directed scenarios plus randomized
// traffic, all checked against a count-based reference model.
module tb_capture_sequencer;
  localparam int E    = 8;
  localparam int LW   = 4;
  localparam int IDLE = 0, PRE = 1, POST = 2, DONE = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1, run = 1'b0, capture_done = 1'b0, smpl_en = 1'b0, trig = 1'b0;
  logic [LW-1:0] trig_pos = 4'd3;
  logic          we, armed, triggered, capturing, set_capture_done;
  logic [LW-1:0] waddr, ram_addr;

  int tests = 0;
  int fails = 0;
  int pulses = 0;

  // Reference model: counts of writes in this capture, addresses derived by modulo.
  int m_phase = IDLE, m_total = 0, m_pre = 0, m_post = 0, m_last = 0;
  bit m_armed = 1'b0, m_trig = 1'b0, m_done = 1'b0;
  logic we_obs = 1'b0, we_exp = 1'b0;

  capture_sequencer #(.ENTRIES(E), .LOG2(LW)) dut (
    .clk(clk), .rst(rst), .run(run), .capture_done(capture_done),
    .smpl_en(smpl_en), .trig(trig), .trig_pos(trig_pos),
    .we(we), .waddr(waddr), .ram_addr(ram_addr), .armed(armed),
    .triggered(triggered), .capturing(capturing), .set_capture_done(set_capture_done)
  );

  always #5 clk = ~clk;

  function automatic int eff_p(input logic [LW-1:0] tp);
    if (int'(tp) == 0) return 1;
    if (int'(tp) >= E) return E - 1;
    return int'(tp);
  endfunction

  function automatic void m_start();
    m_phase = PRE; m_total = 0; m_pre = 0; m_post = 0; m_armed = 1'b0; m_trig = 1'b0;
  endfunction

  function automatic void m_step();
    int ph;
    bit was_armed;
    bit wrote;
    ph = m_phase; was_armed = m_armed; wrote = 1'b0;
    if (rst) begin
      m_phase = IDLE; m_total = 0; m_pre = 0; m_post = 0; m_last = 0;
      m_armed = 1'b0; m_trig = 1'b0; m_done = 1'b0;
      return;
    end
    m_done = 1'b0;
    if (ph == IDLE) begin
      if (run && !capture_done) m_start();
    end else if (ph == DONE) begin
      if (!capture_done) begin
        if (run) m_start();
        else m_phase = IDLE;
      end
    end else if (!run || capture_done) begin
      m_phase = IDLE; m_armed = 1'b0; m_trig = 1'b0;
    end else begin
      if (smpl_en) begin
        m_last = m_total % E;
        m_total++;
        wrote = 1'b1;
        if (ph == PRE) m_pre++;
        else m_post++;
      end
      if (ph == PRE) begin
        if (m_pre >= E - eff_p(trig_pos)) m_armed = 1'b1;
        if (trig && was_armed) begin
          m_phase = POST; m_trig = 1'b1;
        end
      end else if (wrote && m_post == eff_p(trig_pos)) begin
        m_phase = DONE; m_done = 1'b1;
      end
    end
  endfunction

  function automatic logic [12:0] exp_vec();
    logic cap;
    cap = (m_phase == PRE) || (m_phase == POST);
    return {we_exp, LW'(m_total % E), LW'(m_last), m_armed, m_trig, cap, m_done};
  endfunction

  function automatic logic [12:0] obs_vec();
    return {we_obs, waddr, ram_addr, armed, triggered, capturing, set_capture_done};
  endfunction

  task automatic drive(input logic [3:0] v);
    {run, capture_done, smpl_en, trig} = v;
  endtask

  task automatic tick();
    @(negedge clk);
    we_obs = we;
    we_exp = ((m_phase == PRE) || (m_phase == POST)) && smpl_en && run && !capture_done;
    @(posedge clk);
    m_step();
    #1;
    if (set_capture_done === 1'b1) pulses++;
  endtask

  task automatic reset_dut();
    rst = 1'b1; drive(4'b0000); tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; drive(4'b1010);
    tick(); tick();
    tests++;
    if (obs_vec() !== 13'h0) begin fails++; $display("FAIL reset_zero: got %h expected 0000", obs_vec()); end
    tests++;
    if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL reset_model: got %h expected %h", obs_vec(), exp_vec()); end
    rst = 1'b0; drive(4'b0000); tick();
    tests++;
    if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL reset_idle: got %h expected %h", obs_vec(), exp_vec()); end
  endtask

  task automatic test_basic();
    logic [3:0] seq [13] = '{4'b1000, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1001,
                             4'b1010, 4'b1010, 4'b1010, 4'b1110, 4'b1110, 4'b1110};
    trig_pos = 4'd3;
    reset_dut();
    for (int i = 0; i < 13; i++) begin
      drive(seq[i]); tick();
      tests++;
      if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL basic cyc%0d: got %h expected %h", i, obs_vec(), exp_vec()); end
      if (i == 4) begin
        tests++;
        if (armed !== 1'b0) begin fails++; $display("FAIL basic_armed_early: got %b expected 0", armed); end
      end
      if (i == 5) begin
        tests++;
        if (armed !== 1'b1 || waddr !== 4'd5) begin fails++; $display("FAIL basic_armed: got armed=%b waddr=%0d expected 1/5", armed, waddr); end
      end
      if (i == 9) begin
        tests++;
        if (set_capture_done !== 1'b1 || ram_addr !== 4'd7 || capturing !== 1'b0) begin
          fails++; $display("FAIL basic_done: got done=%b ram_addr=%0d capturing=%b expected 1/7/0", set_capture_done, ram_addr, capturing);
        end
      end
      if (i >= 10) begin
        tests++;
        if (we_obs !== 1'b0 || set_capture_done !== 1'b0 || triggered !== 1'b1) begin
          fails++; $display("FAIL basic_hold: got we=%b done=%b trig=%b expected 0/0/1", we_obs, set_capture_done, triggered);
        end
      end
    end
  endtask

  task automatic test_done_restart();
    drive(4'b1010); tick();
    tests++;
    if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL restart cyc0: got %h expected %h", obs_vec(), exp_vec()); end
    tests++;
    if (we_obs !== 1'b0 || capturing !== 1'b1 || waddr !== 4'd0 || armed !== 1'b0) begin
      fails++; $display("FAIL restart_enter: got we=%b cap=%b waddr=%0d armed=%b expected 0/1/0/0", we_obs, capturing, waddr, armed);
    end
    drive(4'b1010); tick();
    tests++;
    if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL restart cyc1: got %h expected %h", obs_vec(), exp_vec()); end
    tests++;
    if (we_obs !== 1'b1 || ram_addr !== 4'd0 || waddr !== 4'd1) begin
      fails++; $display("FAIL restart_write: got we=%b ram_addr=%0d waddr=%0d expected 1/0/1", we_obs, ram_addr, waddr);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] v;
    trig_pos = 4'd3;
    reset_dut();
    pulses = 0;
    for (int i = 0; i < 23; i++) begin
      v = (i == 0) ? 4'b1000 : (i <= 14) ? 4'b1010 : (i == 15) ? 4'b1001 : (i <= 18) ? 4'b1010 : 4'b1110;
      drive(v); tick();
      tests++;
      if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL wrap cyc%0d: got %h expected %h", i, obs_vec(), exp_vec()); end
      if (i == 14) begin
        tests++;
        if (waddr !== 4'd6 || armed !== 1'b1 || capturing !== 1'b1) begin
          fails++; $display("FAIL wrap_pre: got waddr=%0d armed=%b cap=%b expected 6/1/1", waddr, armed, capturing);
        end
      end
      if (i == 18) begin
        tests++;
        if (ram_addr !== 4'd0 || set_capture_done !== 1'b1) begin
          fails++; $display("FAIL wrap_done: got ram_addr=%0d done=%b expected 0/1", ram_addr, set_capture_done);
        end
      end
    end
    tests++;
    if (pulses !== 1) begin fails++; $display("FAIL wrap_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_early_trig();
    logic [3:0] v;
    trig_pos = 4'd3;
    reset_dut();
    for (int i = 0; i < 11; i++) begin
      v = (i == 0) ? 4'b1000 : (i == 3 || i == 7) ? 4'b1001 : 4'b1010;
      drive(v); tick();
      tests++;
      if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL early cyc%0d: got %h expected %h", i, obs_vec(), exp_vec()); end
      if (i == 3) begin
        tests++;
        if (triggered !== 1'b0 || armed !== 1'b0 || capturing !== 1'b1) begin
          fails++; $display("FAIL early_ignored: got trig=%b armed=%b cap=%b expected 0/0/1", triggered, armed, capturing);
        end
      end
      if (i == 7) begin
        tests++;
        if (triggered !== 1'b1) begin fails++; $display("FAIL early_accept: got %b expected 1", triggered); end
      end
      if (i == 10) begin
        tests++;
        if (set_capture_done !== 1'b1 || ram_addr !== 4'd7) begin
          fails++; $display("FAIL early_done: got done=%b ram_addr=%0d expected 1/7", set_capture_done, ram_addr);
        end
      end
    end
  endtask

  task automatic test_abort();
    logic [3:0] v;
    trig_pos = 4'd3;
    reset_dut();
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      v = (i == 0) ? 4'b1000 : (i <= 5) ? 4'b1010 : (i == 6) ? 4'b1001 : (i == 7) ? 4'b1010 : (i == 8) ? 4'b0010 : 4'b0000;
      drive(v); tick();
      tests++;
      if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL abort cyc%0d: got %h expected %h", i, obs_vec(), exp_vec()); end
      if (i == 8) begin
        tests++;
        if (we_obs !== 1'b0 || capturing !== 1'b0 || armed !== 1'b0 || triggered !== 1'b0 || set_capture_done !== 1'b0) begin
          fails++; $display("FAIL abort_state: got we=%b cap=%b armed=%b trig=%b done=%b expected all 0",
                            we_obs, capturing, armed, triggered, set_capture_done);
        end
      end
    end
    tests++;
    if (pulses !== 0) begin fails++; $display("FAIL abort_pulses: got %0d expected 0", pulses); end
  endtask

  task automatic test_reset_mid();
    trig_pos = 4'd3;
    reset_dut();
    for (int i = 0; i < 7; i++) begin
      rst = (i == 4);
      drive((i == 0 || i >= 4 && i <= 5) ? 4'b1000 : 4'b1010);
      tick();
      tests++;
      if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL rstmid cyc%0d: got %h expected %h", i, obs_vec(), exp_vec()); end
      if (i == 3) begin
        tests++;
        if (waddr !== 4'd3) begin fails++; $display("FAIL rstmid_pre: got waddr=%0d expected 3", waddr); end
      end
      if (i == 4) begin
        tests++;
        if ({waddr, ram_addr, armed, triggered, capturing, set_capture_done} !== 12'h0) begin
          fails++; $display("FAIL rstmid_clear: got waddr=%0d ram_addr=%0d cap=%b expected 0/0/0", waddr, ram_addr, capturing);
        end
      end
      if (i == 6) begin
        tests++;
        if (we_obs !== 1'b1 || ram_addr !== 4'd0 || waddr !== 4'd1) begin
          fails++; $display("FAIL rstmid_restart: got we=%b ram_addr=%0d waddr=%0d expected 1/0/1", we_obs, ram_addr, waddr);
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_clamp();
    logic [LW-1:0] tps [4] = '{4'd0, 4'd9, 4'd8, 4'd1};
    int            ps  [4] = '{1, 7, 7, 1};
    int f;
    logic [3:0] v;
    for (int k = 0; k < 4; k++) begin
      trig_pos = tps[k];
      f = E - ps[k];
      reset_dut();
      for (int i = 0; i <= f + ps[k] + 1; i++) begin
        v = (i == 0) ? 4'b1000 : (i == f + 1) ? 4'b1001 : 4'b1010;
        drive(v); tick();
        tests++;
        if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL clamp tp%0d cyc%0d: got %h expected %h", tps[k], i, obs_vec(), exp_vec()); end
        if (i == f - 1) begin
          tests++;
          if (armed !== 1'b0) begin fails++; $display("FAIL clamp_arm_early tp%0d: got %b expected 0", tps[k], armed); end
        end
        if (i == f) begin
          tests++;
          if (armed !== 1'b1) begin fails++; $display("FAIL clamp_arm tp%0d: got %b expected 1", tps[k], armed); end
        end
        if (i == f + ps[k]) begin
          tests++;
          if (set_capture_done !== 1'b0) begin fails++; $display("FAIL clamp_done_early tp%0d: got %b expected 0", tps[k], set_capture_done); end
        end
      end
      tests++;
      if (set_capture_done !== 1'b1 || ram_addr !== 4'd7) begin
        fails++; $display("FAIL clamp_done tp%0d: got done=%b ram_addr=%0d expected 1/7", tps[k], set_capture_done, ram_addr);
      end
    end
  endtask

  task automatic test_random();
    int cd_hold;
    cd_hold = 0;
    trig_pos = 4'd3;
    reset_dut();
    pulses = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      if ((m_phase == IDLE || m_phase == DONE) && $urandom_range(0, 7) == 0) trig_pos = LW'($urandom_range(0, 15));
      run = ($urandom_range(0, 99) != 0);
      smpl_en = rst ? 1'b0 : ($urandom_range(0, 3) != 0);
      trig = ($urandom_range(0, 5) == 0);
      if (cd_hold > 0) begin
        capture_done = 1'b1; cd_hold--;
      end else begin
        capture_done = ($urandom_range(0, 299) == 0);
      end
      tick();
      tests++;
      if (obs_vec() !== exp_vec()) begin fails++; $display("FAIL random cyc%0d: got %h expected %h", i, obs_vec(), exp_vec()); end
      if (m_done) cd_hold = $urandom_range(1, 5);
    end
    rst = 1'b0;
    tests++;
    if (pulses < 20) begin fails++; $display("FAIL random_completions: got %0d expected at least 20", pulses); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_done_restart();
    test_wrap();
    test_early_trig();
    test_abort();
    test_reset_mid();
    test_clamp();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
